alu_ctrl_md: RTL and testbench
==============================

Name: alu_ctrl_md

Overview:
Next-generation ALU control for the RV32/RV64 core. It keeps the base ALUop/funct3/funct7 decode and adds RV-M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) handling through an iterative multiply/divide sequencer. It sits between decode and execute. It stalls the front end through in_ready while an M-op iterates. It drives either a registered ALUctrl or a mul/div result to writeback.

Parameters:
XLEN, 32, operand/result width (32 or 64)
REG_CTRL, 1, 1 = ALUctrl registered (valid the cycle after accept); 0 = combinational, out_valid still registered

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents an op
in_ready  output  1  block can accept; equals (state==IDLE)
ALUop  input  2  00 ld/st/jump, 01 branch, 10 R-type, 11 I-type
funct3  input  3  instruction funct3
funct7_30  input  1  instruction bit 30
funct7_0  input  1  instruction bit 25; selects RV-M when ALUop=10
rs1_val  input  XLEN  operand A (used only for M-ops)
rs2_val  input  XLEN  operand B (used only for M-ops)
kill  input  1  pipeline flush; aborts the in-flight op
ALUctrl  output  4  ALU operation code
md_sel  output  1  1 = md_result is the writeback value
md_result  output  XLEN  mul/div result
out_valid  output  1  one-cycle pulse per completed op

Behaviour:
- Reset values (async, immediate on rst): state=IDLE, ALUctrl=0010 (ADD), md_sel=0, md_result=0, out_valid=0, internal accumulators=0. in_ready=1 after reset.
- ALUctrl codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SUB 0110, SLT 0111, SLTU 1000, SRL 1010, NOR 1100, SRA 1101.
- Decode, non-M:
  - ALUop 00 -> ADD.
  - ALUop 01: f3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; others -> SUB.
  - ALUop 10 with funct7_0=0, by f3: 000 -> ADD (SUB if funct7_30); 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR; 101 -> SRL (SRA if funct7_30); 110 -> OR; 111 -> AND.
  - ALUop 11: same as ALUop 10, except f3=000 is always ADD and funct7_0 is ignored.
- Accept = in_valid & in_ready. Nothing is captured when not accepted.
- Non-M accept:
  - Next cycle: ALUctrl updated, out_valid=1 for one cycle, md_sel=0.
  - State stays IDLE, so back-to-back accepts are allowed every cycle.
- M-op accept (ALUop=10, funct7_0=1):
  - Capture the operands; state IDLE -> CALC; in_ready drops the following cycle.
  - ALUctrl holds its previous value.
- Multiply:
  - Convert to magnitudes per signedness. MUL and MULH are signed x signed; MULHSU is signed x unsigned; MULHU is unsigned x unsigned.
  - Unsigned shift-add, one bit per cycle, XLEN cycles, 2*XLEN-bit product.
  - Negate the product if the operand signs differ.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide:
  - Restoring, one quotient bit per cycle, XLEN cycles, on magnitudes.
  - Signed quotient is negated if the operand signs differ. Signed remainder takes the sign of the dividend.
- Latency: accept at cycle 0, CALC occupies cycles 1..XLEN, then state DONE. In DONE: out_valid=1, md_sel=1, md_result valid; state -> IDLE next cycle. Total XLEN+1 cycles to out_valid.
- Short path (state IDLE -> DONE directly, out_valid at cycle 1):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = most-negative, rs2 = all ones): DIV -> rs1; REM -> 0.
- md_result and md_sel hold their values until the next completion. md_sel clears on the next non-M completion.
- kill:
  - In CALC or DONE: state -> IDLE next cycle, no out_valid, md_result unchanged.
  - kill in the same cycle as an accept cancels the accept.
  - kill in IDLE has no effect.
- in_valid is ignored while in_ready=0; decode must hold the op.
- rst asserted mid-CALC: all outputs are at reset values immediately; no completion is produced after rst releases.

Test Plan:
- ALUop=10, f3=000, f7_30=1, f7_0=0 -> next cycle ALUctrl=0110, out_valid pulse of 1 cycle, md_sel=0. Then ALUop=11, f3=101, f7_30=1 on the following cycle -> ALUctrl=1101 (back-to-back accept).
- MUL rs1=0xFFFFFFFD (-3), rs2=7 -> in_ready=0 for cycles 1..33, out_valid at cycle 33, md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV rs1=5, rs2=0 -> out_valid at cycle 1, md_result=0xFFFFFFFF. REMU 5 by 0 -> 5. DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- DIV -7 by 2 -> 0xFFFFFFFD, cycle 33. REM -7 by 2 -> 0xFFFFFFFF. DIVU 100 by 7 -> 14. REMU 100 by 7 -> 2.
- MUL accepted, kill at cycle 10 -> no out_valid, in_ready=1 at cycle 11. The next ADD decode completes normally.
- rst pulsed at cycle 5 of a DIV -> ALUctrl=0010, out_valid=0, md_result=0 immediately. in_ready=1 after release, and no stale completion is produced.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// ALU control decode with an iterative RV-M multiply/divide sequencer.
// Non-M ops complete in one cycle; M-ops iterate one bit per cycle and stall decode via in_ready.
module alu_ctrl_md #(
  parameter int XLEN     = 32,
  parameter bit REG_CTRL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUop,
  input  logic [2:0]      funct3,
  input  logic            funct7_30,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            kill,
  output logic [3:0]      ALUctrl,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            out_valid
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_XOR = 4'b0011, C_SLL = 4'b0100, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_SLTU = 4'b1000, C_SRL = 4'b1010,
                         C_SRA = 4'b1101;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      ctrl_q, ctrl_d, dec_ctrl;
  logic            md_sel_q, md_sel_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl = C_ADD;
    case (ALUop)
      2'b00: dec_ctrl = C_ADD;
      2'b01: begin
        case (funct3[2:1])
          2'b10:   dec_ctrl = C_SLT;
          2'b11:   dec_ctrl = C_SLTU;
          default: dec_ctrl = C_SUB;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  dec_ctrl = (ALUop == 2'b10 && funct7_30) ? C_SUB : C_ADD;
          3'b001:  dec_ctrl = C_SLL;
          3'b010:  dec_ctrl = C_SLT;
          3'b011:  dec_ctrl = C_SLTU;
          3'b100:  dec_ctrl = C_XOR;
          3'b101:  dec_ctrl = funct7_30 ? C_SRA : C_SRL;
          3'b110:  dec_ctrl = C_OR;
          default: dec_ctrl = C_AND;
        endcase
      end
    endcase
  end

  // Operand preparation: magnitudes, sign of the final result, and the short-path cases.
  logic            accept, is_m, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, short_res;

  always_comb begin
    accept    = in_valid & in_ready & ~kill;
    is_m      = (ALUop == 2'b10) && funct7_0;
    a_neg     = (funct3[2] ? ~funct3[0] : (funct3 != 3'b011)) & rs1_val[XLEN-1];
    b_neg     = (funct3[2] ? ~funct3[0] : ~funct3[1]) & rs2_val[XLEN-1];
    a_mag     = a_neg ? -rs1_val : rs1_val;
    b_mag     = b_neg ? -rs2_val : rs2_val;
    div_zero  = funct3[2] && (rs2_val == '0);
    div_ovf   = funct3[2] && !funct3[0] && (rs1_val == MOST_NEG) && (rs2_val == '1);
    short_res = div_zero ? (funct3[1] ? rs1_val : '1) : (funct3[1] ? '0 : rs1_val);
  end

  // One iteration of shift-add multiply or restoring divide, plus the sign-corrected result.
  logic [XLEN:0]     sum, rem_shift;
  logic [XLEN-1:0]   step_hi, step_lo, q_s, r_s, fin_res;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {hi_q, lo_q[XLEN-1]};
    if (!op_q[2]) begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end else if (rem_shift >= {1'b0, opnd_q}) begin
      step_hi = XLEN'(rem_shift - {1'b0, opnd_q});
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = rem_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -step_lo : step_lo;
    r_s    = neg_q ? -step_hi : step_hi;
    if (!op_q[2]) fin_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else          fin_res = op_q[1] ? r_s : q_s;
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    md_sel_d    = md_sel_q;
    md_result_d = md_result_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_m) begin
          op_d  = funct3;
          // Remainder follows the dividend's sign; everything else follows sign difference.
          neg_d = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = CW'(XLEN - 1);
          if (div_zero || div_ovf) begin
            md_result_d = short_res;
            md_sel_d    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = funct3[2] ? a_mag : b_mag;
            opnd_d  = funct3[2] ? b_mag : a_mag;
            state_d = CALC;
          end
        end else if (accept) begin
          ctrl_d      = dec_ctrl;
          md_sel_d    = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == '0) begin
            md_result_d = fin_res;
            md_sel_d    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= C_ADD;
      md_sel_q    <= 1'b0;
      md_result_q <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      md_sel_q    <= md_sel_d;
      md_result_q <= md_result_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ALUctrl   = REG_CTRL ? ctrl_q : dec_ctrl;
  assign md_sel    = md_sel_q;
  assign md_result = md_result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_ctrl_md;

  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, kill = 1'b0;
  logic [1:0]  ALUop = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_30 = 1'b0, funct7_0 = 1'b0;
  logic [31:0] rs1_val = '0, rs2_val = '0, md_result;
  logic [3:0]  ALUctrl;
  logic        md_sel, out_valid;

  int n_cmp = 0, n_bad = 0;
  logic [3:0]  last_ctrl = 4'b0010;
  logic [31:0] last_res  = '0;
  logic        last_sel  = 1'b0;

  alu_ctrl_md #(.XLEN(32), .REG_CTRL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .funct3(funct3), .funct7_30(funct7_30), .funct7_0(funct7_0),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .kill(kill), .ALUctrl(ALUctrl),
    .md_sel(md_sel), .md_result(md_result), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] aop, input logic [2:0] f3, input logic f30);
    if (aop == 2'b00) return 4'b0010;
    if (aop == 2'b01) begin
      if (f3 == 3'd4 || f3 == 3'd5) return 4'b0111;
      if (f3 == 3'd6 || f3 == 3'd7) return 4'b1000;
      return 4'b0110;
    end
    case (f3)
      3'd0: return (aop == 2'b10 && f30) ? 4'b0110 : 4'b0010;
      3'd1: return 4'b0100;
      3'd2: return 4'b0111;
      3'd3: return 4'b1000;
      3'd4: return 4'b0011;
      3'd5: return f30 ? 4'b1101 : 4'b1010;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = {32'b0, b};
    ovf = (a == MOST_NEG) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op, waits (bounded) for its completion and checks result, latency and flags.
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f30, input logic f70, input logic [31:0] a, input logic [31:0] b);
    logic is_m;
    int lat, exp_lat;
    is_m = (aop == 2'b10) && f70;
    if (is_m) begin
      last_res = ref_md(f3, a, b);
      last_sel = 1'b1;
      exp_lat  = (f3[2] && (b == 0 || (!f3[0] && a == MOST_NEG && b == 32'hFFFF_FFFF))) ? 1 : 33;
    end else begin
      last_ctrl = ref_ctrl(aop, f3, f30);
      last_sel  = 1'b0;
      exp_lat   = 1;
    end
    check({tag, " ready_before"}, 64'(in_ready), 64'(1));
    ALUop = aop; funct3 = f3; funct7_30 = f30; funct7_0 = f70;
    rs1_val = a; rs2_val = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    if (exp_lat > 1) check({tag, " stall"}, 64'(in_ready), 64'(0));
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(md_result), 64'(last_res));
    check({tag, " md_sel"}, 64'(md_sel), 64'(last_sel));
    check({tag, " ctrl"}, 64'(ALUctrl), 64'(last_ctrl));
    check({tag, " ready_done"}, 64'(in_ready), 64'(!is_m));
    @(negedge clk);
    check({tag, " pulse_end"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  aop;
    logic [2:0]  f3;
    int          seen;

    repeat (3) @(negedge clk);
    check("reset ctrl", 64'(ALUctrl), 64'(4'b0010));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset md_result", 64'(md_result), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset md_sel", 64'(md_sel), 64'(0));

    // Back-to-back SUB then I-type SRA.
    ALUop = 2'b10; funct3 = 3'b000; funct7_30 = 1'b1; funct7_0 = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    check("b2b sub ctrl", 64'(ALUctrl), 64'(4'b0110));
    check("b2b sub valid", 64'(out_valid), 64'(1));
    check("b2b sub md_sel", 64'(md_sel), 64'(0));
    ALUop = 2'b11; funct3 = 3'b101; funct7_30 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("b2b sra ctrl", 64'(ALUctrl), 64'(4'b1101));
    check("b2b sra valid", 64'(out_valid), 64'(1));
    last_ctrl = 4'b1101;
    @(negedge clk);
    check("b2b pulse_end", 64'(out_valid), 64'(0));

    run_op("mul",    2'b10, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    run_op("mulhu",  2'b10, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 2'b10, 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    run_op("div0",   2'b10, 3'd4, 1'b0, 1'b1, 32'd5, 32'd0);
    run_op("remu0",  2'b10, 3'd7, 1'b0, 1'b1, 32'd5, 32'd0);
    run_op("divovf", 2'b10, 3'd4, 1'b0, 1'b1, MOST_NEG, 32'hFFFF_FFFF);
    run_op("removf", 2'b10, 3'd6, 1'b0, 1'b1, MOST_NEG, 32'hFFFF_FFFF);
    run_op("div",    2'b10, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",    2'b10, 3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",   2'b10, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7);
    run_op("remu",   2'b10, 3'd7, 1'b0, 1'b1, 32'd100, 32'd7);

    // Kill a multiply during its iterations.
    ALUop = 2'b10; funct3 = 3'd0; funct7_0 = 1'b1; rs1_val = 32'd9; rs2_val = 32'd9; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); @(negedge clk);
    kill = 1'b0;
    check("kill in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("kill no_valid", 64'(seen), 64'(0));
    check("kill md_result", 64'(md_result), 64'(last_res));
    run_op("post_kill add", 2'b00, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Kill in the same cycle as an accept cancels it.
    ALUop = 2'b10; funct3 = 3'd4; funct7_0 = 1'b0; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("kill_acc valid", 64'(out_valid), 64'(0));
    check("kill_acc ctrl", 64'(ALUctrl), 64'(last_ctrl));

    // Reset in the middle of a divide.
    run_op("pre_rst xor", 2'b10, 3'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    ALUop = 2'b10; funct3 = 3'd5; funct7_0 = 1'b1; rs1_val = 32'd1000; rs2_val = 32'd3; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst ctrl", 64'(ALUctrl), 64'(4'b0010));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst md_result", 64'(md_result), 64'(0));
    check("rst md_sel", 64'(md_sel), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    last_ctrl = 4'b0010; last_res = '0; last_sel = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("rst no_stale", 64'(seen), 64'(0));

    // Randomized mix of decode and M-ops.
    for (int n = 0; n < 80; n++) begin
      aop = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = MOST_NEG; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($signed($urandom_range(0, 40)) - 20); rb = 32'($signed($urandom_range(0, 40)) - 20); end
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if (n % 2 == 0)
        run_op("rand_m", 2'b10, f3, 1'($urandom_range(0, 1)), 1'b1, ra, rb);
      else
        run_op("rand_dec", aop, f3, 1'($urandom_range(0, 1)), 1'b0, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
